// File: rtl/spe_potential_scheduler_if.sv
// ---------------------------------------------------------------------------
// spe_potential_scheduler_if
//   Request/response bundle between the Sum PE bank and the potential
//   scheduler.
//
//   Handshake: a request from SPE i transfers in a cycle where
//   req_valid[i] && req_ready[i] is high on the rising clock edge. The
//   requester holds valid and payload stable until that cycle. req_ready is
//   one-hot or zero. rsp_valid and spike_valid are single-cycle strobes with
//   no back-pressure.
//
//   Signals
//     req_valid  [N_SPE]            per-SPE request valid
//     req_ready  [N_SPE]            one-hot grant
//     req_wr     [N_SPE]            1 = writeback, 0 = read previous potential
//     req_addr   [N_SPE*ADDR_W]     neuron index, SPE i at [i*ADDR_W +: ADDR_W]
//     req_wdata  [N_SPE*SUM_WIDTH]  new potential
//     req_spike  [N_SPE]            spike bit that goes with a writeback
//     rsp_valid                     read response strobe
//     rsp_id     [ID_W]             SPE that owns the response
//     rsp_data   [SUM_WIDTH]        previous potential
//     spike_valid                   strobe per stored write with spike=1
//     spike_addr [ADDR_W]           neuron index of that spike
//   Modports: master = Sum PE bank side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface spe_potential_scheduler_if #(
    parameter int N_SPE     = 5,
    parameter int SUM_WIDTH = 13,
    parameter int ADDR_W    = 9
);
    localparam int ID_W = (N_SPE > 1) ? $clog2(N_SPE) : 1;

    logic [N_SPE-1:0]           req_valid;
    logic [N_SPE-1:0]           req_ready;
    logic [N_SPE-1:0]           req_wr;
    logic [N_SPE*ADDR_W-1:0]    req_addr;
    logic [N_SPE*SUM_WIDTH-1:0] req_wdata;
    logic [N_SPE-1:0]           req_spike;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [SUM_WIDTH-1:0]       rsp_data;
    logic                       spike_valid;
    logic [ADDR_W-1:0]          spike_addr;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_spike,
        input  req_ready, rsp_valid, rsp_id, rsp_data, spike_valid, spike_addr
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_spike,
        output req_ready, rsp_valid, rsp_id, rsp_data, spike_valid, spike_addr
    );
endinterface

// File: rtl/spe_potential_scheduler.sv
// ---------------------------------------------------------------------------
// spe_potential_scheduler
//   Shared membrane-potential store and access scheduler for the Sum PE
//   bank. A round-robin arbiter grants one SPE per cycle. A read returns the
//   previous potential one cycle later. A writeback stores the new potential
//   and counts it. When every output neuron of the timestep has been written,
//   the timestep advances. After NUM_TS timesteps the block parks in DONE.
//
//   Ports
//     clk, reset   rising-edge clock, asynchronous active-high reset
//     bus          spe_potential_scheduler_if.slave (requests, responses, spikes)
//     ts           current timestep, starts at 1
//     ts_done      one-cycle pulse while the timestep advances
//     all_done     high once all timesteps have finished
//     err          sticky duplicate/out-of-range write flag (dup-check build)
//     dbg_state    FSM state: 0 RUN, 1 RESP, 2 TS_ADV, 3 DONE
//     dbg_wr_cnt   writebacks counted in the current timestep
//     dbg_rr_ptr   round-robin start position
//
//   Build option
//     OMEM_DUP_CHECK_EN  When defined, a per-timestep written bitmap rejects
//                        repeated writes and out-of-range writes and sets err.
//                        When undefined, repeated in-range writes overwrite
//                        and are counted, and err is tied 0.
// ---------------------------------------------------------------------------
module spe_potential_scheduler #(
    parameter int N_SPE     = 5,
    parameter int SUM_WIDTH = 13,
    parameter int NUM_OUT   = 441,
    parameter int ADDR_W    = 9,
    parameter int NUM_TS    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    spe_potential_scheduler_if.slave           bus,
    output logic [1:0]                         ts,
    output logic                               ts_done,
    output logic                               all_done,
    output logic                               err,
    output logic [1:0]                         dbg_state,
    output logic [$clog2(NUM_OUT+1)-1:0]       dbg_wr_cnt,
    output logic [((N_SPE > 1) ? $clog2(N_SPE) : 1)-1:0] dbg_rr_ptr
);
    localparam int ID_W  = (N_SPE > 1) ? $clog2(N_SPE) : 1;
    localparam int CNT_W = $clog2(NUM_OUT + 1);
    localparam logic [ADDR_W:0] NUM_OUT_W = (ADDR_W + 1)'(NUM_OUT);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_RESP   = 2'd1;
    localparam logic [1:0] ST_TS_ADV = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     wr_cnt;
    logic [ID_W-1:0]      rr_ptr;
    logic [SUM_WIDTH-1:0] mem [NUM_OUT];

    // Per-SPE payload views.
    logic [ADDR_W-1:0]    addr_arr  [N_SPE];
    logic [SUM_WIDTH-1:0] wdata_arr [N_SPE];

    for (genvar g = 0; g < N_SPE; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = bus.req_wdata[g*SUM_WIDTH +: SUM_WIDTH];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;
    int              arb_idx;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        arb_idx   = 0;
        for (int k = 0; k < N_SPE; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= N_SPE) arb_idx = arb_idx - N_SPE;
            cand = ID_W'(arb_idx);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Grants are offered only in RUN, so RESP/TS_ADV/DONE stall every SPE.
    logic accept;
    assign accept = (state == ST_RUN) && win_found;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[win_id] = 1'b1;
    end

    logic                 sel_wr;
    logic                 sel_spike;
    logic [ADDR_W-1:0]    sel_addr;
    logic [SUM_WIDTH-1:0] sel_wdata;
    logic                 in_range;
    logic                 dup_hit;
    logic                 write_ok;

    assign sel_wr    = bus.req_wr[win_id];
    assign sel_spike = bus.req_spike[win_id];
    assign sel_addr  = addr_arr[win_id];
    assign sel_wdata = wdata_arr[win_id];
    assign in_range  = {1'b0, sel_addr} < NUM_OUT_W;
    assign write_ok  = accept && sel_wr && in_range && !dup_hit;

`ifdef OMEM_DUP_CHECK_EN
    logic [NUM_OUT-1:0] written;
    logic               err_q;
    logic               bad_write;

    assign dup_hit   = in_range && written[sel_addr];
    assign bad_write = accept && sel_wr && !write_ok;
    assign err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_TS_ADV) begin
                written <= '0;
            end else if (write_ok) begin
                written[sel_addr] <= 1'b1;
            end
            if (bad_write) err_q <= 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Potential store: not reset; ts==1 reads are forced to 0 instead.
    always_ff @(posedge clk) begin
        if (write_ok) mem[sel_addr] <= sel_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_RUN;
            ts              <= 2'd1;
            wr_cnt          <= '0;
            rr_ptr          <= '0;
            bus.rsp_id      <= '0;
            bus.rsp_data    <= '0;
            bus.spike_valid <= 1'b0;
            bus.spike_addr  <= '0;
        end else begin
            bus.spike_valid <= write_ok && sel_spike;
            if (write_ok) bus.spike_addr <= sel_addr;

            case (state)
                ST_RUN: begin
                    if (accept) begin
                        rr_ptr <= (win_id == ID_W'(N_SPE - 1)) ? '0 : win_id + 1'b1;
                        if (!sel_wr) begin
                            bus.rsp_id   <= win_id;
                            bus.rsp_data <= (ts == 2'd1 || !in_range) ? '0 : mem[sel_addr];
                            state        <= ST_RESP;
                        end else if (write_ok) begin
                            wr_cnt <= wr_cnt + 1'b1;
                            if (wr_cnt == CNT_W'(NUM_OUT - 1)) state <= ST_TS_ADV;
                        end
                    end
                end
                ST_RESP: state <= ST_RUN;
                ST_TS_ADV: begin
                    wr_cnt <= '0;
                    if (int'(ts) < NUM_TS) begin
                        ts    <= ts + 2'd1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.rsp_valid = (state == ST_RESP);
    assign ts_done       = (state == ST_TS_ADV);
    assign all_done      = (state == ST_DONE);
    assign dbg_state     = state;
    assign dbg_wr_cnt    = wr_cnt;
    assign dbg_rr_ptr    = rr_ptr;
endmodule

// File: tb/tb_spe_potential_scheduler.sv
module tb_spe_potential_scheduler;
    localparam int N_SPE     = 5;
    localparam int SUM_WIDTH = 13;
    localparam int NUM_OUT   = 441;
    localparam int ADDR_W    = 9;
    localparam int NUM_TS    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ts;
    logic       ts_done, all_done, err;
    logic [1:0] dbg_state;
    logic [8:0] dbg_wr_cnt;
    logic [2:0] dbg_rr_ptr;

    int checks = 0;
    int errors = 0;

    spe_potential_scheduler_if #(.N_SPE(N_SPE), .SUM_WIDTH(SUM_WIDTH), .ADDR_W(ADDR_W)) bus ();

    spe_potential_scheduler #(
        .N_SPE(N_SPE), .SUM_WIDTH(SUM_WIDTH), .NUM_OUT(NUM_OUT),
        .ADDR_W(ADDR_W), .NUM_TS(NUM_TS)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .ts(ts), .ts_done(ts_done),
        .all_done(all_done), .err(err), .dbg_state(dbg_state),
        .dbg_wr_cnt(dbg_wr_cnt), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time exceeded, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [12:0] mem_m   [NUM_OUT];
    bit          wr_m    [NUM_OUT];
    bit          known_m [NUM_OUT];
    int          ts_m, cnt_m, rr_m;
    bit          err_m, done_m;

    task automatic model_reset();
        ts_m = 1; cnt_m = 0; rr_m = 0; err_m = 0; done_m = 0;
        for (int i = 0; i < NUM_OUT; i++) wr_m[i] = 0;
    endtask

    task automatic model_write(input int id, input int addr, input logic [12:0] d,
                               output bit stored, output bit adv);
        rr_m   = (id + 1) % N_SPE;
        stored = (addr < NUM_OUT);
`ifdef OMEM_DUP_CHECK_EN
        if (stored && wr_m[addr]) stored = 0;
        if (!stored) err_m = 1;
`endif
        adv = 0;
        if (stored) begin
            mem_m[addr] = d; known_m[addr] = 1; wr_m[addr] = 1;
            cnt_m++;
            if (cnt_m == NUM_OUT) begin
                adv = 1; cnt_m = 0;
                for (int i = 0; i < NUM_OUT; i++) wr_m[i] = 0;
                if (ts_m < NUM_TS) ts_m++; else done_m = 1;
            end
        end
    endtask

    task automatic model_read(input int id, input int addr, output logic [12:0] exp_d);
        rr_m  = (id + 1) % N_SPE;
        exp_d = (ts_m == 1 || addr >= NUM_OUT) ? 13'd0 : mem_m[addr];
    endtask

    function automatic int model_winner(input logic [4:0] mask);
        for (int k = 0; k < N_SPE; k++)
            if (mask[(rr_m + k) % N_SPE]) return (rr_m + k) % N_SPE;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    typedef struct {
        logic [4:0]  ready;
        logic        rsp_valid;
        logic [2:0]  rsp_id;
        logic [12:0] rsp_data;
        logic        spike_valid;
        logic [8:0]  spike_addr;
        logic        ts_done;
        logic [8:0]  wr_cnt;
        logic        err;
        logic        rsp_after;
    } obs_t;

    task automatic clear_bus();
        bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_spike = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Single request from one SPE; called and returning at the falling edge.
    task automatic xfer_one(input int id, input bit wr, input int addr,
                            input logic [12:0] d, input bit sp, output obs_t o);
        clear_bus();
        bus.req_valid[id] = 1'b1;
        bus.req_wr[id]    = wr;
        bus.req_spike[id] = sp;
        bus.req_addr[id*ADDR_W +: ADDR_W]       = ADDR_W'(addr);
        bus.req_wdata[id*SUM_WIDTH +: SUM_WIDTH] = d;
        #1 o.ready = bus.req_ready;
        @(posedge clk); #1;
        clear_bus();
        o.rsp_valid   = bus.rsp_valid;
        o.rsp_id      = bus.rsp_id;
        o.rsp_data    = bus.rsp_data;
        o.spike_valid = bus.spike_valid;
        o.spike_addr  = bus.spike_addr;
        o.ts_done     = ts_done;
        o.wr_cnt      = dbg_wr_cnt;
        o.err         = err;
        o.rsp_after   = 1'b0;
        if (!wr) begin
            @(posedge clk); #1;
            o.rsp_after = bus.rsp_valid;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_bus();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({bus.rsp_valid, bus.spike_valid, ts_done, all_done, err} !== 5'b0 || ts !== 2'd1) begin
            errors++;
            $display("FAIL reset_hold: strobes=%b ts=%0d exp strobes=00000 ts=1",
                     {bus.rsp_valid, bus.spike_valid, ts_done, all_done, err}, ts);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.req_ready !== 5'b0 || bus.rsp_id !== 3'd0 || bus.rsp_data !== 13'd0 || bus.spike_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b id=%0d data=%0d saddr=%0d exp all 0",
                     bus.req_ready, bus.rsp_id, bus.rsp_data, bus.spike_addr);
        end
        checks++;
        if (dbg_wr_cnt !== 9'd0 || dbg_rr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL reset_counters: wr_cnt=%0d rr_ptr=%0d exp 0 0", dbg_wr_cnt, dbg_rr_ptr);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [4:0]  mask;
        int          w;
        logic [12:0] exp_d;
        apply_reset();
        for (int r = 0; r < 16; r++) begin
            mask = (r < 6) ? 5'b11111 : 5'($urandom_range(31, 1));
            clear_bus();
            bus.req_valid = mask;
            bus.req_addr  = {N_SPE{9'd3}};
            w = model_winner(mask);
            model_read(w, 3, exp_d);
            #1;
            checks++;
            if (bus.req_ready !== 5'(1 << w)) begin
                errors++;
                $display("FAIL rr_grant round %0d: mask=%b ready=%b exp %b", r, mask, bus.req_ready, 5'(1 << w));
            end
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 3'(w) || bus.rsp_data !== exp_d) begin
                errors++;
                $display("FAIL rr_resp round %0d: valid=%b id=%0d data=%0d exp 1 %0d %0d",
                         r, bus.rsp_valid, bus.rsp_id, bus.rsp_data, w, exp_d);
            end
            @(negedge clk); #1;
            checks++;
            if (bus.req_ready !== 5'b0) begin
                errors++;
                $display("FAIL rr_resp_stall round %0d: ready=%b exp 00000", r, bus.req_ready);
            end
            @(negedge clk);
        end
        clear_bus();
        checks++;
        if (dbg_rr_ptr !== 3'(rr_m)) begin
            errors++;
            $display("FAIL rr_ptr_end: got %0d exp %0d", dbg_rr_ptr, rr_m);
        end
    endtask

    task automatic test_read_ts1();
        obs_t        o;
        logic [12:0] exp_d;
        int          id, a;
        apply_reset();
        model_read(2, 7, exp_d);
        xfer_one(2, 0, 7, 13'd0, 0, o);
        checks++;
        if (o.ready !== 5'b00100 || o.rsp_valid !== 1'b1 || o.rsp_id !== 3'd2 || o.rsp_data !== exp_d || o.rsp_after !== 1'b0) begin
            errors++;
            $display("FAIL read_ts1_spe2: ready=%b v=%b id=%0d data=%0d after=%b exp 00100 1 2 %0d 0",
                     o.ready, o.rsp_valid, o.rsp_id, o.rsp_data, o.rsp_after, exp_d);
        end
        checks++;
        if (dbg_rr_ptr !== 3'd3) begin
            errors++;
            $display("FAIL read_ts1_rr: got %0d exp 3", dbg_rr_ptr);
        end
        repeat (6) begin
            id = $urandom_range(N_SPE - 1, 0);
            a  = $urandom_range(511, 0);
            model_read(id, a, exp_d);
            xfer_one(id, 0, a, 13'd0, 0, o);
            checks++;
            if (o.rsp_valid !== 1'b1 || o.rsp_id !== 3'(id) || o.rsp_data !== exp_d) begin
                errors++;
                $display("FAIL read_ts1_rand addr %0d: v=%b id=%0d data=%0d exp 1 %0d %0d",
                         a, o.rsp_valid, o.rsp_id, o.rsp_data, id, exp_d);
            end
        end
    endtask

    task automatic test_write_spike();
        obs_t        o;
        bit          stored, adv;
        logic [12:0] d;
        int          id;
        model_write(0, 10, 13'd40, stored, adv);
        xfer_one(0, 1, 10, 13'd40, 1, o);
        checks++;
        if (o.ready !== 5'b00001 || o.spike_valid !== 1'b1 || o.spike_addr !== 9'd10 || o.wr_cnt !== 9'(cnt_m)) begin
            errors++;
            $display("FAIL write_spike: ready=%b sv=%b saddr=%0d wr_cnt=%0d exp 00001 1 10 %0d",
                     o.ready, o.spike_valid, o.spike_addr, o.wr_cnt, cnt_m);
        end
        id = $urandom_range(N_SPE - 1, 0);
        d  = 13'($urandom);
        model_write(id, 11, d, stored, adv);
        xfer_one(id, 1, 11, d, 0, o);
        checks++;
        if (o.spike_valid !== 1'b0 || o.wr_cnt !== 9'(cnt_m)) begin
            errors++;
            $display("FAIL write_nospike: sv=%b wr_cnt=%0d exp 0 %0d", o.spike_valid, o.wr_cnt, cnt_m);
        end
    endtask

    task automatic test_fill_ts1();
        obs_t        o;
        bit          stored, adv;
        logic [12:0] d;
        int          id, a, tmp, j;
        bit          sp;
        int          addrs[$];
        for (int i = 0; i < NUM_OUT; i++) if (i != 10 && i != 11) addrs.push_back(i);
        for (int i = addrs.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = addrs[i]; addrs[i] = addrs[j]; addrs[j] = tmp;
        end
        // Repeat write to addr 10 with the same value, then an out-of-range write.
        model_write(1, 10, 13'd40, stored, adv);
        xfer_one(1, 1, 10, 13'd40, 0, o);
        checks++;
        if (o.wr_cnt !== 9'(cnt_m) || o.err !== err_m) begin
            errors++;
            $display("FAIL dup_write: wr_cnt=%0d err=%b exp %0d %b", o.wr_cnt, o.err, cnt_m, err_m);
        end
        a = $urandom_range(511, NUM_OUT);
        model_write(4, a, 13'd99, stored, adv);
        xfer_one(4, 1, a, 13'd99, 1, o);
        checks++;
        if (o.spike_valid !== 1'b0 || o.wr_cnt !== 9'(cnt_m) || o.err !== err_m) begin
            errors++;
            $display("FAIL oob_write addr %0d: sv=%b wr_cnt=%0d err=%b exp 0 %0d %b",
                     a, o.spike_valid, o.wr_cnt, o.err, cnt_m, err_m);
        end
        for (int i = 0; i < addrs.size() && ts_m == 1; i++) begin
            id = $urandom_range(N_SPE - 1, 0);
            d  = 13'($urandom);
            sp = 1'($urandom_range(1, 0));
            model_write(id, addrs[i], d, stored, adv);
            xfer_one(id, 1, addrs[i], d, sp, o);
            checks++;
            if (o.ready !== 5'(1 << id) || o.spike_valid !== (stored && sp) ||
                (stored && sp && o.spike_addr !== 9'(addrs[i]))) begin
                errors++;
                $display("FAIL fill1_write addr %0d: ready=%b sv=%b saddr=%0d exp %b %b %0d",
                         addrs[i], o.ready, o.spike_valid, o.spike_addr, 5'(1 << id), stored && sp, addrs[i]);
            end
            checks++;
            if (o.ts_done !== adv || o.wr_cnt !== 9'(adv ? NUM_OUT : cnt_m)) begin
                errors++;
                $display("FAIL fill1_count addr %0d: ts_done=%b wr_cnt=%0d exp %b %0d",
                         addrs[i], o.ts_done, o.wr_cnt, adv, adv ? NUM_OUT : cnt_m);
            end
        end
        // Now in the advance cycle: nothing may be granted.
        bus.req_valid = '1;
        #1;
        checks++;
        if (bus.req_ready !== 5'b0 || ts_done !== 1'b1) begin
            errors++;
            $display("FAIL ts_adv_cycle: ready=%b ts_done=%b exp 00000 1", bus.req_ready, ts_done);
        end
        clear_bus();
        @(negedge clk); #1;
        checks++;
        if (ts !== 2'(ts_m) || ts_done !== 1'b0 || dbg_wr_cnt !== 9'd0 || all_done !== 1'b0) begin
            errors++;
            $display("FAIL ts_after_adv: ts=%0d ts_done=%b wr_cnt=%0d all_done=%b exp %0d 0 0 0",
                     ts, ts_done, dbg_wr_cnt, all_done, ts_m);
        end
        @(negedge clk);
    endtask

    task automatic test_read_ts2();
        obs_t        o;
        logic [12:0] exp_d;
        int          id, a, tries;
        model_read(3, 10, exp_d);
        xfer_one(3, 0, 10, 13'd0, 0, o);
        checks++;
        if (o.rsp_valid !== 1'b1 || o.rsp_id !== 3'd3 || o.rsp_data !== 13'd40 || exp_d !== 13'd40) begin
            errors++;
            $display("FAIL read_ts2_addr10: v=%b id=%0d data=%0d exp 1 3 40", o.rsp_valid, o.rsp_id, o.rsp_data);
        end
        repeat (12) begin
            id = $urandom_range(N_SPE - 1, 0);
            a  = $urandom_range(511, 0);
            tries = 0;
            while (a < NUM_OUT && !known_m[a] && tries < 50) begin
                a = $urandom_range(511, 0);
                tries++;
            end
            if (a < NUM_OUT && !known_m[a]) a = 10;
            model_read(id, a, exp_d);
            xfer_one(id, 0, a, 13'd0, 0, o);
            checks++;
            if (o.rsp_valid !== 1'b1 || o.rsp_id !== 3'(id) || o.rsp_data !== exp_d) begin
                errors++;
                $display("FAIL read_ts2_rand addr %0d: v=%b id=%0d data=%0d exp 1 %0d %0d",
                         a, o.rsp_valid, o.rsp_id, o.rsp_data, id, exp_d);
            end
        end
    endtask

    task automatic test_done();
        obs_t        o;
        bit          stored, adv;
        logic [12:0] d;
        int          id, tmp, j;
        bit          sp;
        int          addrs[$];
        for (int i = 0; i < NUM_OUT; i++) addrs.push_back(i);
        for (int i = addrs.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = addrs[i]; addrs[i] = addrs[j]; addrs[j] = tmp;
        end
        for (int i = 0; i < addrs.size() && !done_m; i++) begin
            id = $urandom_range(N_SPE - 1, 0);
            d  = 13'($urandom);
            sp = 1'($urandom_range(1, 0));
            model_write(id, addrs[i], d, stored, adv);
            xfer_one(id, 1, addrs[i], d, sp, o);
            checks++;
            if (o.spike_valid !== (stored && sp) || o.ts_done !== adv) begin
                errors++;
                $display("FAIL fill2_write addr %0d: sv=%b ts_done=%b exp %b %b",
                         addrs[i], o.spike_valid, o.ts_done, stored && sp, adv);
            end
        end
        @(negedge clk);
        bus.req_valid = '1;
        bus.req_wr    = '1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== 5'b0 || all_done !== done_m || ts !== 2'(ts_m) || ts_done !== 1'b0) begin
                errors++;
                $display("FAIL done_hold cycle %0d: ready=%b all_done=%b ts=%0d ts_done=%b exp 00000 %b %0d 0",
                         c, bus.req_ready, all_done, ts, ts_done, done_m, ts_m);
            end
            @(negedge clk);
        end
        clear_bus();
    endtask

    task automatic test_reset_mid_resp();
        obs_t        o;
        bit          stored, adv;
        apply_reset();
        model_write(0, 5, 13'd7, stored, adv);
        xfer_one(0, 1, 5, 13'd7, 0, o);
        model_write(2, 5, 13'd8, stored, adv);
        xfer_one(2, 1, 5, 13'd8, 0, o);
        checks++;
        if (o.wr_cnt !== 9'(cnt_m) || o.err !== err_m) begin
            errors++;
            $display("FAIL addr5_twice: wr_cnt=%0d err=%b exp %0d %b", o.wr_cnt, o.err, cnt_m, err_m);
        end
        bus.req_valid[1] = 1'b1;
        bus.req_addr[1*ADDR_W +: ADDR_W] = 9'd5;
        @(posedge clk); #1;
        clear_bus();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_resp_entry: rsp_valid=%b exp 1", bus.rsp_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || ts !== 2'd1 || err !== 1'b0 || dbg_wr_cnt !== 9'd0 || dbg_rr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: rsp_valid=%b ts=%0d err=%b wr_cnt=%0d rr=%0d exp 0 1 0 0 0",
                     bus.rsp_valid, ts, err, dbg_wr_cnt, dbg_rr_ptr);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_ts1();
        test_write_spike();
        test_fill_ts1();
        test_read_ts2();
        test_done();
        test_reset_mid_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
